// File: rtl/conv_stage_seq.sv
// conv_stage_seq: sequences the five CNN stage phases (weight load, input
// load, systolic compute, ReLU, pooling) in fixed order. Each phase waits
// for its load request, runs for a fixed number of cycles while driving its
// datapath enable and an index, then holds its done flag until the request
// is withdrawn. Loads for any phase other than the current one are flagged
// through a sticky error bit.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_WAIT | waiting for the current phase's load request
//   ST_RUN  | phase active: enable high, addr counts 0..N-1
//   ST_HOLD | phase finished: done high until the load request drops
//
// The phase register (PH_W..PH_P) selects which load/enable/done the
// sub-state refers to.
module conv_stage_seq #(
  parameter int W_CYC = 9,
  parameter int I_CYC = 16,
  parameter int S_CYC = 25,
  parameter int R_CYC = 16,
  parameter int P_CYC = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       w_load_i,
  input  logic       i_load_i,
  input  logic       s_load_i,
  input  logic       r_load_i,
  input  logic       p_load_i,
  output logic       done_w_o,
  output logic       done_i_o,
  output logic       done_s_o,
  output logic       done_r_o,
  output logic       done_p_o,
  output logic       w_en_o,
  output logic       i_en_o,
  output logic       s_en_o,
  output logic       r_en_o,
  output logic       p_en_o,
  output logic [7:0] addr_o,
  output logic       busy_o,
  output logic       err_o
);

  typedef enum logic [2:0] {
    PH_W = 3'd0,
    PH_I = 3'd1,
    PH_S = 3'd2,
    PH_R = 3'd3,
    PH_P = 3'd4
  } phase_e;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } sub_e;

  // Last index of each phase; addr runs 0..N-1 so the run ends at N-1.
  localparam logic [7:0] W_LAST = 8'(W_CYC - 1);
  localparam logic [7:0] I_LAST = 8'(I_CYC - 1);
  localparam logic [7:0] S_LAST = 8'(S_CYC - 1);
  localparam logic [7:0] R_LAST = 8'(R_CYC - 1);
  localparam logic [7:0] P_LAST = 8'(P_CYC - 1);

  phase_e     phase_q, phase_d;
  sub_e       sub_q, sub_d;
  logic [7:0] addr_q, addr_d;
  logic       err_q, err_d;

  logic [4:0] load_vec;
  logic [4:0] cur_mask;
  logic [4:0] en_vec;
  logic [4:0] done_vec;
  logic       cur_load;
  logic       wrong_load;
  logic [7:0] last_addr;
  phase_e     next_phase;

  // Bit order of all 5-bit vectors follows the phase encoding: W is bit 0.
  assign load_vec   = {p_load_i, r_load_i, s_load_i, i_load_i, w_load_i};
  assign cur_mask   = 5'b00001 << phase_q;
  assign cur_load   = |(load_vec & cur_mask);
  assign wrong_load = |(load_vec & ~cur_mask);

  // Per-phase run length and successor phase.
  always_comb begin
    last_addr  = W_LAST;
    next_phase = PH_I;
    case (phase_q)
      PH_W: begin
        last_addr  = W_LAST;
        next_phase = PH_I;
      end
      PH_I: begin
        last_addr  = I_LAST;
        next_phase = PH_S;
      end
      PH_S: begin
        last_addr  = S_LAST;
        next_phase = PH_R;
      end
      PH_R: begin
        last_addr  = R_LAST;
        next_phase = PH_P;
      end
      PH_P: begin
        last_addr  = P_LAST;
        next_phase = PH_W;
      end
      default: begin
        last_addr  = W_LAST;
        next_phase = PH_W;
      end
    endcase
  end

  // Next-state logic for the phase/sub-state machine, index and error flag.
  always_comb begin
    phase_d = phase_q;
    sub_d   = sub_q;
    addr_d  = addr_q;
    err_d   = err_q;
    case (sub_q)
      ST_WAIT: begin
        if (wrong_load) begin
          err_d = 1'b1;
        end
        if (cur_load) begin
          sub_d  = ST_RUN;
          addr_d = 8'd0;
        end
      end
      ST_RUN: begin
        // The load level is not consulted here: a run always completes.
        if (wrong_load) begin
          err_d = 1'b1;
        end
        if (addr_q == last_addr) begin
          sub_d  = ST_HOLD;
          addr_d = 8'd0;
        end else begin
          addr_d = addr_q + 8'd1;
        end
      end
      ST_HOLD: begin
        if (!cur_load) begin
          sub_d   = ST_WAIT;
          phase_d = next_phase;
        end
      end
      default: begin
        sub_d   = ST_WAIT;
        phase_d = PH_W;
        addr_d  = 8'd0;
      end
    endcase
  end

  // State registers with asynchronous abort to WAIT of W.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      phase_q <= PH_W;
      sub_q   <= ST_WAIT;
      addr_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      sub_q   <= sub_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode straight from registered state, so they never glitch
  // and only the current phase's enable/done can be high.
  assign en_vec   = (sub_q == ST_RUN)  ? cur_mask : 5'b00000;
  assign done_vec = (sub_q == ST_HOLD) ? cur_mask : 5'b00000;

  assign w_en_o   = en_vec[0];
  assign i_en_o   = en_vec[1];
  assign s_en_o   = en_vec[2];
  assign r_en_o   = en_vec[3];
  assign p_en_o   = en_vec[4];

  assign done_w_o = done_vec[0];
  assign done_i_o = done_vec[1];
  assign done_s_o = done_vec[2];
  assign done_r_o = done_vec[3];
  assign done_p_o = done_vec[4];

  assign addr_o   = addr_q;
  assign busy_o   = (sub_q == ST_RUN);
  assign err_o    = err_q;

endmodule

// File: tb/tb_conv_stage_seq.sv
// Directed testbench for conv_stage_seq with default phase lengths.
module tb_conv_stage_seq;

  logic       clk;
  logic       reset;
  logic [4:0] loads;
  logic       done_w, done_i, done_s, done_r, done_p;
  logic       w_en, i_en, s_en, r_en, p_en;
  logic [7:0] addr;
  logic       busy;
  logic       err;

  logic [4:0] en_vec;
  logic [4:0] done_vec;

  int n_checks = 0;
  int n_errors = 0;

  int ncyc [5] = '{9, 16, 25, 16, 4};

  assign en_vec   = {p_en, r_en, s_en, i_en, w_en};
  assign done_vec = {done_p, done_r, done_s, done_i, done_w};

  conv_stage_seq dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .w_load_i (loads[0]),
    .i_load_i (loads[1]),
    .s_load_i (loads[2]),
    .r_load_i (loads[3]),
    .p_load_i (loads[4]),
    .done_w_o (done_w),
    .done_i_o (done_i),
    .done_s_o (done_s),
    .done_r_o (done_r),
    .done_p_o (done_p),
    .w_en_o   (w_en),
    .i_en_o   (i_en),
    .s_en_o   (s_en),
    .r_en_o   (r_en),
    .p_en_o   (p_en),
    .addr_o   (addr),
    .busy_o   (busy),
    .err_o    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " en"},   en_vec,   5'b0);
    chk({tag, " done"}, done_vec, 5'b0);
    chk({tag, " addr"}, addr,     8'd0);
    chk({tag, " busy"}, busy,     1'b0);
  endtask

  // Serve one phase: raise its load, follow the run cycle by cycle, then
  // hold the load for hold_extra more cycles (or drop it right after the
  // first sampling edge when early_drop is set) and watch done clear.
  task automatic run_phase(input int idx, input int hold_extra, input bit early_drop);
    logic [4:0] m;
    m = 5'b00001 << idx;
    loads[idx] = 1'b1;
    for (int k = 0; k < ncyc[idx]; k++) begin
      step();
      if (k == 0 && early_drop) loads[idx] = 1'b0;
      chk($sformatf("ph%0d run en", idx),   en_vec,   m);
      chk($sformatf("ph%0d run addr", idx), addr,     k);
      chk($sformatf("ph%0d run done", idx), done_vec, 5'b0);
      chk($sformatf("ph%0d run busy", idx), busy,     1'b1);
    end
    step();
    chk($sformatf("ph%0d hold done", idx), done_vec, m);
    chk($sformatf("ph%0d hold en", idx),   en_vec,   5'b0);
    chk($sformatf("ph%0d hold addr", idx), addr,     8'd0);
    chk($sformatf("ph%0d hold busy", idx), busy,     1'b0);
    if (!early_drop) begin
      for (int k = 0; k < hold_extra; k++) begin
        step();
        chk($sformatf("ph%0d held done", idx), done_vec, m);
        chk($sformatf("ph%0d held en", idx),   en_vec,   5'b0);
      end
      loads[idx] = 1'b0;
    end
    step();
    chk_idle($sformatf("ph%0d exit", idx));
  endtask

  initial begin
    loads = 5'b0;
    reset = 1'b1;
    #1;
    chk_idle("reset async");
    chk("reset err", err, 1'b0);
    step();
    step();
    chk_idle("reset held");
    reset = 1'b0;

    // Full pass: W held 5 cycles after done, S pulsed for one cycle.
    step();
    chk_idle("wait W");
    run_phase(0, 5, 1'b0);
    step();
    step();
    chk_idle("wait I no load");
    run_phase(1, 0, 1'b0);
    run_phase(2, 0, 1'b1);
    run_phase(3, 0, 1'b0);
    run_phase(4, 0, 1'b0);
    chk("pass1 err", err, 1'b0);

    // Back-to-back wrap: W starts on the first edge after P exits.
    for (int p = 0; p < 5; p++) run_phase(p, 0, 1'b0);
    chk("pass2 err", err, 1'b0);

    // Out-of-order request while waiting for I.
    run_phase(0, 0, 1'b0);
    loads[3] = 1'b1;
    step();
    chk("ooo err", err, 1'b1);
    chk_idle("ooo ignored");
    loads[3] = 1'b0;
    step();
    chk_idle("ooo still wait");
    run_phase(1, 0, 1'b0);
    chk("ooo err sticky", err, 1'b1);

    // Reset in the middle of S at addr 10.
    loads[2] = 1'b1;
    for (int k = 0; k <= 10; k++) step();
    chk("midS addr", addr, 8'd10);
    chk("midS en", en_vec, 5'b00100);
    #2 reset = 1'b1;
    #1;
    chk_idle("midS abort");
    chk("midS abort err", err, 1'b0);
    loads[2] = 1'b0;
    step();
    reset = 1'b0;
    #1;
    chk_idle("post reset");

    // After reset the sequence is back at W, so i_load alone is an error.
    loads[1] = 1'b1;
    step();
    chk("i alone err", err, 1'b1);
    chk_idle("i alone ignored");
    loads[1] = 1'b0;

    // Correct and wrong load together in WAIT: flagged but still served.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    loads = 5'b00101;
    step();
    chk("both err", err, 1'b1);
    chk("both en", en_vec, 5'b00001);
    chk("both addr", addr, 8'd0);
    loads = 5'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv_stage_seq.md
CONV_STAGE_SEQ -- requirements
Module: conv_stage_seq

Interface
REQ-001 Parameter W_CYC, default 9, weight-load cycles per request (legal 1..255).
REQ-002 Parameter I_CYC, default 16, input-load cycles per request (legal 1..255).
REQ-003 Parameter S_CYC, default 25, systolic-compute cycles per request (legal 1..255).
REQ-004 Parameter R_CYC, default 16, ReLU cycles per request (legal 1..255).
REQ-005 Parameter P_CYC, default 4, pooling cycles per request (legal 1..255).
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 w_load, i_load, s_load, r_load, p_load  in  1 each  level requests from the CNN controller, one per phase.
REQ-009 done_w, done_i, done_s, done_r, done_p  out  1 each  level completion flags back to the controller.
REQ-010 w_en, i_en, s_en, r_en, p_en  out  1 each  datapath enable, high only while the matching phase runs.
REQ-011 addr  out  8  index within the running phase (0..N-1); 0 when no phase runs.
REQ-012 busy  out  1  high whenever any phase is in RUN.
REQ-013 err  out  1  sticky protocol-error flag.

Function
REQ-014 Phases SHALL be served strictly in order W, I, S, R, P, then wrap to W; each phase has sub-states WAIT, RUN, HOLD.
REQ-015 In WAIT of phase X, the block SHALL move to RUN on the first edge sampling X's load high.
REQ-016 In RUN, the X enable SHALL be high and addr SHALL equal 0 in the first RUN cycle, incrementing by 1 per cycle to N_X-1.
REQ-017 On the edge after addr = N_X-1, the block SHALL enter HOLD, drop the enable, return addr to 0, and raise done_X.
REQ-018 Latency: load sampled at edge t -> enable high for exactly N_X cycles after t -> done_X high after edge t+N_X.
REQ-019 Deasserting X's load during RUN SHALL be ignored; the run completes with its full N_X cycles.
REQ-020 In HOLD, done_X SHALL stay high until an edge samples X's load low; that edge clears done_X and moves to WAIT of the next phase.
REQ-021 done_X SHALL be high for at least one cycle, including when load is already low in the first HOLD cycle.
REQ-022 At most one done and at most one enable SHALL be high at any time.
REQ-023 Any load other than the current phase's load sampled high in WAIT or RUN SHALL set err and otherwise be ignored.
REQ-024 If the correct load and a wrong load are sampled high together in WAIT, err SHALL be set and the correct load still accepted.
REQ-025 Once set, err SHALL stay high until reset.
REQ-026 After P's HOLD exits, the block SHALL return to WAIT of W with no idle cycles and no extra output activity.

Reset
REQ-027 While reset is high, the block SHALL be in WAIT of W, with all done, enable, busy and err outputs 0 and addr = 0.
REQ-028 Asserting reset mid-RUN or mid-HOLD SHALL abort immediately (asynchronously) to the reset state.
REQ-029 After reset deasserts, the first edge SHALL behave as a WAIT-of-W edge.

Verification
REQ-030 Full pass with defaults: each load is raised, then dropped after its done -> w_en 9 cycles, addr 0..8; done_w; then i_en 16, s_en 25, r_en 16, p_en 4; done flags in order; err = 0.
REQ-031 Held load: w_load held high 5 cycles after done_w -> done_w stays high 5 cycles, clears on the edge sampling w_load low, and i_en does not assert before i_load.
REQ-032 Early drop: s_load pulsed for 1 cycle -> s_en still high for 25 cycles and done_s asserts; done_s clears on the first HOLD edge.
REQ-033 Out-of-order: r_load raised while in WAIT of I -> err = 1, no r_en; the following i_load is served normally with 16 cycles.
REQ-034 Reset mid-S at addr = 10 -> all outputs 0 asynchronously; after release, the sequence restarts at W and i_load alone sets err.
REQ-035 Wrap: two back-to-back full passes -> the second W phase starts on the first edge sampling w_load after the P HOLD exits, addr restarts at 0, with no glitch on any done.
